// File: rtl/iroh_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iroh_mem_responder : IrohCPU word store with boot loader stream and CPU hold
// Optional power-on zero sweep: define IROH_MEM_CLEAR_EN.       Rev 1.0
// ---------------------------------------------------------------------------
module iroh_mem_responder #(
  parameter int DEPTH     = 256,
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        cpu_hold,
  output logic [8:0]  ld_count
);

  localparam logic [1:0] c_ST_CLEAR = 2'd0;
  localparam logic [1:0] c_ST_LOAD  = 2'd1;
  localparam logic [1:0] c_ST_RUN   = 2'd2;
  localparam logic [1:0] c_ST_BOOT  = BOOT_LOAD ? c_ST_LOAD : c_ST_RUN;
`ifdef IROH_MEM_CLEAR_EN
  localparam logic [1:0] c_ST_RESET = c_ST_CLEAR;
  localparam logic [7:0] c_LAST     = 8'(DEPTH - 1);
`else
  localparam logic [1:0] c_ST_RESET = c_ST_BOOT;
`endif

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [15:0] r_mem [DEPTH];
  logic        w_we;
  logic [7:0]  w_waddr;
  logic [15:0] w_wdata;
  logic        w_rd;
  logic        w_ld_acc;
  logic [7:0]  w_cpu_idx;
  logic [7:0]  w_ld_idx;
  logic [7:0]  r_clr_ptr;
  logic        w_clr_done;

  // Out-of-range addresses alias back into the array.
  assign w_cpu_idx = 8'(32'(cpu_addr) % DEPTH);
  assign w_ld_idx  = 8'(32'(ld_addr) % DEPTH);
  assign w_ld_acc  = ld_valid & ld_ready;

`ifdef IROH_MEM_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst || r_state != c_ST_CLEAR) r_clr_ptr <= '0;
    else                              r_clr_ptr <= r_clr_ptr + 8'd1;
  end
  assign w_clr_done = (r_clr_ptr == c_LAST);
`else
  assign r_clr_ptr  = '0;
  assign w_clr_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_ST_RESET;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_CLEAR: if (w_clr_done) w_next = c_ST_BOOT;
      c_ST_LOAD:  if (w_ld_acc && ld_last) w_next = c_ST_RUN;
      c_ST_RUN:   w_next = c_ST_RUN;
      default:    w_next = c_ST_RESET;
    endcase
  end

  // Single write port: the CPU always wins over a loader patch in RUN.
  always_comb begin
    ld_ready = 1'b0;
    cpu_hold = 1'b1;
    w_rd     = 1'b0;
    w_we     = 1'b0;
    w_waddr  = w_ld_idx;
    w_wdata  = ld_data;
    if (!rst) begin
      case (r_state)
        c_ST_CLEAR: begin
          w_we    = 1'b1;
          w_waddr = r_clr_ptr;
          w_wdata = '0;
        end
        c_ST_LOAD: begin
          ld_ready = 1'b1;
          w_we     = ld_valid;
        end
        c_ST_RUN: begin
          cpu_hold = 1'b0;
          ld_ready = ~cpu_en;
          if (cpu_en) begin
            w_rd    = ~cpu_we;
            w_we    = cpu_we;
            w_waddr = w_cpu_idx;
            w_wdata = cpu_wdata;
          end else begin
            w_we = ld_valid;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      ld_count   <= '0;
    end else begin
      cpu_rvalid <= w_rd;
      if (w_rd) cpu_rdata <= r_mem[w_cpu_idx];
      if (w_ld_acc && ld_count != 9'h1FF) ld_count <= ld_count + 9'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iroh_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iroh_mem_responder : vector table, corner sequences and random run
// against a transaction-level memory model.                     Rev 1.0
// ---------------------------------------------------------------------------
module tb_iroh_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        ld_valid = 1'b0, ld_ready, ld_last = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        cpu_hold;
  logic [8:0]  ld_count;

  iroh_mem_responder #(.DEPTH(256), .BOOT_LOAD(1'b1)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .cpu_hold(cpu_hold), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: what the memory holds, whether the CPU is released, how much
  // of the power-on sweep remains, and what the read port should show.
  logic [15:0] m_mem [256];
  bit          m_known [256];
  bit          m_run;
  int          m_clear;
  int          m_count;
  logic [15:0] m_rdata;
  bit          m_rd_known;
  bit          m_rvalid;
  logic        pre_ready, pre_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run      = 1'b0;
`ifdef IROH_MEM_CLEAR_EN
    m_clear    = 256;
`else
    m_clear    = 0;
`endif
    m_count    = 0;
    m_rdata    = '0;
    m_rd_known = 1'b1;
    m_rvalid   = 1'b0;
  endtask

  task automatic mwrite(input logic [7:0] a, input logic [15:0] d);
    m_mem[a]   = d;
    m_known[a] = 1'b1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [15:0] d);
    mwrite(a, d);
    if (m_count < 511) m_count++;
  endtask

  task automatic step(input logic r, input logic en, input logic we, input logic [7:0] a,
                      input logic [15:0] wd, input logic lv, input logic [7:0] la,
                      input logic [15:0] ld, input logic ll);
    logic e_ready, e_hold;
    rst = r; cpu_en = en; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    ld_valid = lv; ld_addr = la; ld_data = ld; ld_last = ll;
    #1;
    pre_ready = ld_ready;
    pre_hold  = cpu_hold;
    if (r)                e_ready = 1'b0;
    else if (m_clear > 0) e_ready = 1'b0;
    else if (!m_run)      e_ready = 1'b1;
    else                  e_ready = ~en;
    e_hold = r | (m_clear > 0) | ~m_run;
    chk("ld_ready", 32'(ld_ready), 32'(e_ready));
    chk("cpu_hold", 32'(cpu_hold), 32'(e_hold));
    @(posedge clk);
    #1;
    if (r) model_reset();
    else begin
      m_rvalid = 1'b0;
      if (m_clear > 0) begin
        mwrite(8'(256 - m_clear), 16'h0000);
        m_clear--;
      end else if (!m_run) begin
        if (lv) begin
          beat(la, ld);
          if (ll) m_run = 1'b1;
        end
      end else if (en) begin
        if (we) mwrite(a, wd);
        else begin
          m_rdata    = m_mem[a];
          m_rd_known = m_known[a];
          m_rvalid   = 1'b1;
        end
      end else if (lv) begin
        beat(la, ld);
      end
    end
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rvalid));
    chk("ld_count", 32'(ld_count), 32'(m_count));
    if (m_rd_known) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 16'h0, 0, 8'h00, 16'h0, 0);
  endtask

  typedef struct {
    logic en, we; logic [7:0] a; logic [15:0] wd;
    logic lv; logic [7:0] la; logic [15:0] ld; logic ll;
    logic e_ready, e_hold, e_rvalid; logic [15:0] e_rdata; int e_count;
  } vec_t;

  vec_t vt [15];

  initial begin
    vt[0]  = '{1, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 1, 1, 0, 16'h0000, 0};
    vt[1]  = '{0, 0, 8'h00, 16'h0000, 1, 8'h00, 16'h3A05, 0, 1, 1, 0, 16'h0000, 1};
    vt[2]  = '{0, 0, 8'h00, 16'h0000, 1, 8'h01, 16'h0812, 0, 1, 1, 0, 16'h0000, 2};
    vt[3]  = '{0, 0, 8'h00, 16'h0000, 1, 8'h02, 16'h0100, 1, 1, 1, 0, 16'h0000, 3};
    vt[4]  = '{1, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h3A05, 3};
    vt[5]  = '{1, 0, 8'h01, 16'h0000, 0, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h0812, 3};
    vt[6]  = '{1, 0, 8'h02, 16'h0000, 0, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h0100, 3};
    vt[7]  = '{1, 1, 8'h40, 16'h00AB, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0100, 3};
    vt[8]  = '{1, 0, 8'h40, 16'h0000, 0, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h00AB, 3};
    vt[9]  = '{0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 1, 0, 0, 16'h00AB, 3};
    vt[10] = '{1, 0, 8'h00, 16'h0000, 1, 8'h41, 16'h1234, 0, 0, 0, 1, 16'h3A05, 3};
    vt[11] = '{1, 0, 8'h00, 16'h0000, 1, 8'h41, 16'h1234, 0, 0, 0, 1, 16'h3A05, 3};
    vt[12] = '{1, 0, 8'h00, 16'h0000, 1, 8'h41, 16'h1234, 0, 0, 0, 1, 16'h3A05, 3};
    vt[13] = '{0, 0, 8'h00, 16'h0000, 1, 8'h41, 16'h1234, 1, 1, 0, 0, 16'h3A05, 4};
    vt[14] = '{1, 0, 8'h41, 16'h0000, 0, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h1234, 4};

    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    model_reset();

    // Reset state
    step(1, 0, 0, 8'h00, 16'h0, 0, 8'h00, 16'h0, 0);
    step(1, 1, 0, 8'h00, 16'h0, 1, 8'h05, 16'h7777, 1);
    chk("rst_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("rst_count", 32'(ld_count), 32'h0);
    chk("rst_hold", 32'(pre_hold), 32'h1);
    chk("rst_ready", 32'(pre_ready), 32'h0);
`ifdef IROH_MEM_CLEAR_EN
    idle(256);
`endif

    // Boot image, RUN read/write, CPU-priority stall of a loader patch
    for (int i = 0; i < 15; i++) begin
      step(0, vt[i].en, vt[i].we, vt[i].a, vt[i].wd, vt[i].lv, vt[i].la, vt[i].ld, vt[i].ll);
      chk($sformatf("tbl%0d_ready", i), 32'(pre_ready), 32'(vt[i].e_ready));
      chk($sformatf("tbl%0d_hold", i), 32'(pre_hold), 32'(vt[i].e_hold));
      chk($sformatf("tbl%0d_rvalid", i), 32'(cpu_rvalid), 32'(vt[i].e_rvalid));
      chk($sformatf("tbl%0d_rdata", i), 32'(cpu_rdata), 32'(vt[i].e_rdata));
      chk($sformatf("tbl%0d_count", i), 32'(ld_count), 32'(vt[i].e_count));
    end

    // Reset mid-RUN drops a pending read; reset mid-LOAD restarts the image
    step(0, 1, 1, 8'h12, 16'h1111, 0, 8'h00, 16'h0, 0);
    step(1, 1, 0, 8'h12, 16'h0, 0, 8'h00, 16'h0, 0);
    chk("rstrun_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("rstrun_rdata", 32'(cpu_rdata), 32'h0);
`ifdef IROH_MEM_CLEAR_EN
    idle(256);
`endif
    step(0, 0, 0, 8'h00, 16'h0, 1, 8'h10, 16'hAAAA, 0);
    step(0, 0, 0, 8'h00, 16'h0, 1, 8'h11, 16'hBBBB, 0);
    chk("midload_count2", 32'(ld_count), 32'd2);
    step(1, 0, 0, 8'h00, 16'h0, 1, 8'h12, 16'hDEAD, 0);
    chk("midload_count0", 32'(ld_count), 32'd0);
    chk("midload_hold", 32'(pre_hold), 32'h1);
`ifdef IROH_MEM_CLEAR_EN
    idle(256);
`endif
    step(0, 0, 0, 8'h00, 16'h0, 1, 8'h13, 16'h5555, 1);
    chk("reload_count", 32'(ld_count), 32'd1);
    step(0, 1, 0, 8'h12, 16'h0, 0, 8'h00, 16'h0, 0);
    chk("reload_hold", 32'(pre_hold), 32'h0);
    chk("reload_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("noresetwrite", 32'(cpu_rdata == 16'hDEAD), 32'h0);
    step(0, 1, 0, 8'h10, 16'h0, 0, 8'h00, 16'h0, 0);
    chk("reload_beat", 32'(cpu_rdata), 32'hAAAA);

    // Contents across reset: survive by default, zeroed by the sweep
    step(0, 1, 1, 8'hFF, 16'hBEEF, 0, 8'h00, 16'h0, 0);
    step(1, 0, 0, 8'h00, 16'h0, 0, 8'h00, 16'h0, 0);
`ifdef IROH_MEM_CLEAR_EN
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 0, 8'hFF, 16'h0, 0, 8'h00, 16'h0, 0);
      chk("sweep_hold", 32'(pre_hold), 32'h1);
    end
`endif
    step(0, 0, 0, 8'h00, 16'h0, 1, 8'h20, 16'h0F0F, 1);
    step(0, 1, 0, 8'hFF, 16'h0, 0, 8'h00, 16'h0, 0);
`ifdef IROH_MEM_CLEAR_EN
    chk("persist_ff", 32'(cpu_rdata), 32'h0000);
`else
    chk("persist_ff", 32'(cpu_rdata), 32'hBEEF);
`endif

    // Randomised traffic with occasional resets
    for (int i = 0; i < 256; i++) step(0, 1, 1, 8'(i), 16'($urandom), 0, 8'h00, 16'h0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), 8'($urandom),
           16'($urandom), 1'($urandom), 8'($urandom), 16'($urandom),
           ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
